// File: rtl/shift_wb_if.sv
// Handshake bundle between the SRA unit, the shift write-back stage and the register file.
// The master side feeds results in and accepts write-backs.
// The slave side is the write-back stage itself.
interface shift_wb_if #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4,
  parameter int SH_W   = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_src;
  logic [SH_W-1:0]   in_shamt;
  logic [RD_W-1:0]   in_rd;
  logic              in_wen;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [RD_W-1:0]   wb_rd;
  logic              wb_wen;

  modport master (
    output in_valid, in_result, in_src, in_shamt, in_rd, in_wen, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_rd, wb_wen
  );

  modport slave (
    input  in_valid, in_result, in_src, in_shamt, in_rd, in_wen, wb_ready,
    output in_ready, wb_valid, wb_data, wb_rd, wb_wen
  );
endinterface

// File: rtl/shift_wb_stage.sv
// Shift write-back stage.
// A 2-entry FIFO buffers arithmetic-right-shift results ahead of the register file.
// Each entry's zero, negative and carry flags are captured when the entry is enqueued.
// The architectural flags and the retire counter commit when an entry with wen=1 leaves the FIFO.
module shift_wb_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4,
  parameter int SH_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  shift_wb_if.slave   bus,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c,
  output logic [15:0] retire_cnt
);

  logic [DATA_W-1:0] mem_result [2];
  logic [RD_W-1:0]   mem_rd     [2];
  logic              mem_wen    [2];
  logic              mem_z      [2];
  logic              mem_n      [2];
  logic              mem_c      [2];

  logic       head;
  logic       tail;
  logic [1:0] count;

  logic            enq;
  logic            deq;
  logic [SH_W-1:0] sh_idx;
  logic            in_z;
  logic            in_n;
  logic            in_c;

  // Handshake status is decoded from the occupancy register only, so there is no input-to-output path.
  assign bus.in_ready = (count != 2'd2);
  assign bus.wb_valid = (count != 2'd0);
  assign bus.wb_data  = mem_result[head];
  assign bus.wb_rd    = mem_rd[head];
  assign bus.wb_wen   = mem_wen[head];

  assign enq = bus.in_valid && bus.in_ready;
  assign deq = bus.wb_valid && bus.wb_ready;

  // The carry is the last bit shifted out, which is src[shamt-1]. A zero shift produces no carry.
  assign sh_idx = bus.in_shamt - SH_W'(1);
  assign in_z   = (bus.in_result == '0);
  assign in_n   = bus.in_result[DATA_W-1];
  assign in_c   = (bus.in_shamt == '0) ? 1'b0 : bus.in_src[sh_idx];

  // Entry payload is written at the tail. It is left unreset because it is ignored while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_result[tail] <= bus.in_result;
      mem_rd[tail]     <= bus.in_rd;
      mem_wen[tail]    <= bus.in_wen;
      mem_z[tail]      <= in_z;
      mem_n[tail]      <= in_n;
      mem_c[tail]      <= in_c;
    end
  end

  // Pointers, occupancy, architectural flags and the retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= 2'd0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_c     <= 1'b0;
      retire_cnt <= 16'd0;
    end else begin
      if (enq) begin
        tail <= ~tail;
      end
      if (deq) begin
        head <= ~head;
        if (mem_wen[head]) begin
          flag_z     <= mem_z[head];
          flag_n     <= mem_n[head];
          flag_c     <= mem_c[head];
          retire_cnt <= retire_cnt + 16'd1;
        end
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_wb_stage.sv
// Directed testbench for shift_wb_stage.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_shift_wb_stage;
  logic        clk;
  logic        rst;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic [15:0] retire_cnt;

  int total;
  int bad;

  shift_wb_if #(.DATA_W(16), .RD_W(4), .SH_W(4)) bus ();

  shift_wb_stage #(.DATA_W(16), .RD_W(4), .SH_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_c     (flag_c),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] src, input logic [3:0] shamt,
                       input logic [15:0] res, input logic [3:0] rd, input logic wen);
    bus.in_valid  = v;
    bus.in_src    = src;
    bus.in_shamt  = shamt;
    bus.in_result = res;
    bus.in_rd     = rd;
    bus.in_wen    = wen;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.wb_ready = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
    chk("rst_retire", 32'(retire_cnt), 32'd0);

    // Basic enqueue, then write-back one cycle later.
    bus.wb_ready = 1'b1;
    drive(1'b1, 16'hC200, 4'd2, 16'hF080, 4'd3, 1'b1);
    tick();
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    chk("t1_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("t1_wb_data", 32'(bus.wb_data), 32'hF080);
    chk("t1_wb_rd", 32'(bus.wb_rd), 32'd3);
    chk("t1_wb_wen", 32'(bus.wb_wen), 32'd1);
    tick();
    chk("t1_empty", 32'(bus.wb_valid), 32'd0);
    chk("t1_flags_zn_c", {29'd0, flag_z, flag_n, flag_c}, 32'b010);
    chk("t1_retire", 32'(retire_cnt), 32'd1);

    // Fill the FIFO, check backpressure, then drain it in order.
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'h0, 4'd0, 16'h0001, 4'd1, 1'b1);
    tick();
    chk("t2_ready_one", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 16'h0, 4'd0, 16'h0002, 4'd2, 1'b1);
    tick();
    chk("t2_full_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_head", 32'(bus.wb_data), 32'h0001);
    drive(1'b1, 16'h0, 4'd0, 16'h0003, 4'd5, 1'b1);
    tick();
    chk("t2_ignored_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_hold_data", 32'(bus.wb_data), 32'h0001);
    chk("t2_hold_rd", 32'(bus.wb_rd), 32'd1);
    chk("t2_no_retire", 32'(retire_cnt), 32'd1);
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    bus.wb_ready = 1'b1;
    tick();
    chk("t2_second", 32'(bus.wb_data), 32'h0002);
    chk("t2_second_valid", 32'(bus.wb_valid), 32'd1);
    chk("t2_ready_back", 32'(bus.in_ready), 32'd1);
    chk("t2_retire1", 32'(retire_cnt), 32'd2);
    tick();
    chk("t2_drained", 32'(bus.wb_valid), 32'd0);
    chk("t2_retire2", 32'(retire_cnt), 32'd3);

    // Carry and zero flags.
    drive(1'b1, 16'h0003, 4'd1, 16'h0001, 4'd4, 1'b1);
    tick();
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    tick();
    chk("t3_c_set", {29'd0, flag_z, flag_n, flag_c}, 32'b001);
    chk("t3_retire", 32'(retire_cnt), 32'd4);
    drive(1'b1, 16'h0003, 4'd0, 16'h0003, 4'd4, 1'b1);
    tick();
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    tick();
    chk("t3_c_shamt0", {29'd0, flag_z, flag_n, flag_c}, 32'b000);
    drive(1'b1, 16'h0000, 4'd0, 16'h0000, 4'd4, 1'b1);
    tick();
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    tick();
    chk("t3_z_set", {29'd0, flag_z, flag_n, flag_c}, 32'b100);
    drive(1'b1, 16'h4000, 4'd15, 16'h0000, 4'd4, 1'b1);
    tick();
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    tick();
    chk("t3_c_shamt15", {29'd0, flag_z, flag_n, flag_c}, 32'b101);
    chk("t3_retire_end", 32'(retire_cnt), 32'd7);

    // Streaming at occupancy 1 with a simultaneous enqueue and dequeue each cycle.
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'h0, 4'd0, 16'h0100, 4'd6, 1'b1);
    tick();
    bus.wb_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      chk("t4_before", 32'(bus.wb_data), 32'h0100 + 32'(i) - 32'd1);
      drive(1'b1, 16'h0, 4'd0, 16'h0100 + 16'(i), 4'd6, 1'b1);
      tick();
      chk("t4_after", 32'(bus.wb_data), 32'h0100 + 32'(i));
      chk("t4_count1", {30'd0, bus.wb_valid, bus.in_ready}, 32'b11);
    end
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    tick();
    chk("t4_drained", 32'(bus.wb_valid), 32'd0);
    chk("t4_retire", 32'(retire_cnt), 32'd18);

    // An entry with wen=0 must not touch the flags or the retire count.
    drive(1'b1, 16'h0001, 4'd1, 16'h0000, 4'd7, 1'b0);
    tick();
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    chk("t5_wen0_wb_wen", 32'(bus.wb_wen), 32'd0);
    tick();
    chk("t5_wen0_flags", {29'd0, flag_z, flag_n, flag_c}, 32'b000);
    chk("t5_wen0_retire", 32'(retire_cnt), 32'd18);

    // Bring retire_cnt to 0xFFFF with 65517 streamed retires, then wrap it.
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'h0, 4'd0, 16'h1234, 4'd1, 1'b1);
    tick();
    bus.wb_ready = 1'b1;
    repeat (65516) tick();
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    tick();
    chk("t5_retire_max", 32'(retire_cnt), 32'hFFFF);
    drive(1'b1, 16'h0, 4'd0, 16'h8000, 4'd2, 1'b1);
    tick();
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    tick();
    chk("t5_retire_wrap", 32'(retire_cnt), 32'd0);
    chk("t5_wrap_flags", {29'd0, flag_z, flag_n, flag_c}, 32'b010);

    // Reset with two entries buffered and wb_ready high.
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'h0, 4'd0, 16'h0AAA, 4'd1, 1'b1);
    tick();
    drive(1'b1, 16'h0, 4'd0, 16'h0BBB, 4'd2, 1'b1);
    tick();
    chk("t6_full", {30'd0, bus.wb_valid, bus.in_ready}, 32'b10);
    chk("t6_pre_retire", 32'(retire_cnt), 32'd0);
    rst = 1'b1;
    bus.wb_ready = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    chk("t6_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t6_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
    chk("t6_retire", 32'(retire_cnt), 32'd0);
    tick();
    chk("t6_stay_empty", 32'(bus.wb_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
